// File: rtl/amstrad_pkg.sv
// Shared definitions for the Amstrad video-RAM fetch path: lane width and
// variable byte-lane extraction from a (maximum-width) vram word.
package amstrad_pkg;

  localparam int VRAM_LANE_W = 8;
  localparam int MAX_LANES   = 8;

  typedef logic [VRAM_LANE_W*MAX_LANES-1:0] vram_word_t;

  function automatic logic [VRAM_LANE_W-1:0] lane_sel(input vram_word_t word,
                                                      input logic [2:0] idx);
    return word[int'(idx)*VRAM_LANE_W +: VRAM_LANE_W];
  endfunction

endpackage

// File: rtl/amstrad_lane_mux.sv
// Combinational BYTES-way byte selector over a vram word; lane k occupies
// bits [8k+7:8k]. Shared between the video fetch and CPU-side byte reads.
module amstrad_lane_mux
  import amstrad_pkg::*;
#(
  parameter  int BYTES = 2,
  localparam int IW    = $clog2(BYTES)
) (
  input  logic [VRAM_LANE_W*BYTES-1:0] word,
  input  logic [IW-1:0]                sel,
  output logic [VRAM_LANE_W-1:0]       dout
);

  vram_word_t wide;

  // Narrow words are zero-padded so out-of-range selects read as zero.
  always_comb begin
    wide                        = '0;
    wide[VRAM_LANE_W*BYTES-1:0] = word;
    dout                        = lane_sel(wide, 3'(sel));
  end

endmodule

// File: rtl/amstrad_vram_fetch.sv
// Video-RAM byte sequencer: steps one byte lane per CAS strobe within a video
// slot, with an optional one-lane delayed (sync-filter shift) byte stream.
module amstrad_vram_fetch
  import amstrad_pkg::*;
#(
  parameter  int BYTES    = 2,
  parameter  bit SHIFT_EN = 1'b1,
  localparam int IW       = $clog2(BYTES)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         cpu_n,
  input  logic                         ras_n,
  input  logic                         cas_n,
  input  logic                         de,
  input  logic                         shift_mode,
  input  logic [VRAM_LANE_W*BYTES-1:0] vram_din,
  output logic [VRAM_LANE_W-1:0]       vram_dout,
  output logic [IW-1:0]                lane,
  output logic                         strobe,
  output logic                         overrun
);

  logic                   cas_q;
  logic                   load_q;
  logic                   load;
  logic                   cas_end;
  logic                   shift_act;
  logic                   last_lane;
  logic [IW-1:0]          mux_sel;
  logic [VRAM_LANE_W-1:0] mux_byte;
  logic [VRAM_LANE_W-1:0] carry;
  logic [VRAM_LANE_W-1:0] dout_nxt;

  assign load      = ~ras_n & ~cas_n & cpu_n;
  assign cas_end   = ~ras_n & ~cas_q & cas_n;
  assign shift_act = SHIFT_EN & shift_mode;
  assign last_lane = (lane == IW'(BYTES - 1));

  // In shift mode the stream lags one lane; lane 0 replays the previous slot's last byte.
  assign mux_sel  = shift_act ? (lane - IW'(1)) : lane;
  assign dout_nxt = (shift_act && lane == '0) ? carry : mux_byte;

  amstrad_lane_mux #(
    .BYTES (BYTES)
  ) u_lane_mux (
    .word (vram_din),
    .sel  (mux_sel),
    .dout (mux_byte)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cas_q     <= 1'b1;
      load_q    <= 1'b0;
      strobe    <= 1'b0;
      lane      <= '0;
      overrun   <= 1'b0;
      vram_dout <= '0;
    end else begin
      cas_q  <= cas_n;
      load_q <= load;
      strobe <= load & ~load_q;
      // Reloading every cycle of the window follows the SDRAM data as it settles.
      if (load) vram_dout <= dout_nxt;
      if (!cpu_n) begin
        lane <= '0;
      end else if (cas_end) begin
        if (last_lane) overrun <= 1'b1;
        else           lane    <= lane + IW'(1);
      end
    end
  end

  if (SHIFT_EN) begin : g_carry
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        carry <= '0;
      end else if (load && shift_mode && last_lane) begin
        carry <= de ? vram_din[VRAM_LANE_W*(BYTES-1) +: VRAM_LANE_W] : '0;
      end
    end
  end else begin : g_no_carry
    assign carry = '0;
  end

endmodule

// File: tb/tb_amstrad_vram_fetch.sv
// Bench for amstrad_vram_fetch: BYTES=2 and BYTES=4 instances share stimulus and
// are compared every cycle against a slot-level behavioural model.
module tb_amstrad_vram_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_n, ras_n, cas_n, de, shift_mode;
  logic [31:0] vram_din;
  logic [7:0]  dout2, dout4;
  logic        lane2;
  logic [1:0]  lane4;
  logic        strobe2, strobe4, ovr2, ovr4;

  always #5 clk = ~clk;

  amstrad_vram_fetch #(.BYTES(2), .SHIFT_EN(1'b1)) dut2 (
    .clk(clk), .reset_n(reset_n), .cpu_n(cpu_n), .ras_n(ras_n), .cas_n(cas_n),
    .de(de), .shift_mode(shift_mode), .vram_din(vram_din[15:0]),
    .vram_dout(dout2), .lane(lane2), .strobe(strobe2), .overrun(ovr2)
  );

  amstrad_vram_fetch #(.BYTES(4), .SHIFT_EN(1'b1)) dut4 (
    .clk(clk), .reset_n(reset_n), .cpu_n(cpu_n), .ras_n(ras_n), .cas_n(cas_n),
    .de(de), .shift_mode(shift_mode), .vram_din(vram_din),
    .vram_dout(dout4), .lane(lane4), .strobe(strobe4), .overrun(ovr4)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Model: lane is the number of completed CAS strobes in the slot, clamped.
  int         nb [2] = '{2, 4};
  logic [7:0] m_dout  [2];
  logic [7:0] m_carry [2];
  int         m_ends  [2];
  bit         m_strobe[2];
  bit         m_ovr   [2];
  bit         m_casq;
  bit         m_inload;

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
    logic [31:0] t;
    t = w >> (8 * k);
    return t[7:0];
  endfunction

  function automatic int m_lane(input int i);
    return (m_ends[i] < nb[i] - 1) ? m_ends[i] : nb[i] - 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_dout[i] = 8'h00; m_carry[i] = 8'h00; m_ends[i] = 0;
      m_strobe[i] = 1'b0; m_ovr[i] = 1'b0;
    end
    m_casq   = 1'b1;
    m_inload = 1'b0;
  endtask

  task automatic model_step();
    bit load, cend;
    int ln;
    load = cpu_n && !ras_n && !cas_n;
    cend = !ras_n && !m_casq && cas_n;
    for (int i = 0; i < 2; i++) begin
      ln = m_lane(i);
      m_strobe[i] = load && !m_inload;
      if (load) begin
        if (shift_mode) begin
          m_dout[i] = (ln == 0) ? m_carry[i] : byte_of(vram_din, ln - 1);
          if (ln == nb[i] - 1) m_carry[i] = de ? byte_of(vram_din, nb[i] - 1) : 8'h00;
        end else begin
          m_dout[i] = byte_of(vram_din, ln);
        end
      end
      if (!cpu_n) m_ends[i] = 0;
      else if (cend) begin
        if (m_ends[i] >= nb[i] - 1) m_ovr[i] = 1'b1;
        m_ends[i]++;
      end
    end
    m_casq   = cas_n;
    m_inload = load;
  endtask

  task automatic compare(input string ph);
    chk({ph, ".dout2"},   32'(dout2),   32'(m_dout[0]));
    chk({ph, ".lane2"},   32'(lane2),   32'(m_lane(0)));
    chk({ph, ".strobe2"}, 32'(strobe2), 32'(m_strobe[0]));
    chk({ph, ".ovr2"},    32'(ovr2),    32'(m_ovr[0]));
    chk({ph, ".dout4"},   32'(dout4),   32'(m_dout[1]));
    chk({ph, ".lane4"},   32'(lane4),   32'(m_lane(1)));
    chk({ph, ".strobe4"}, 32'(strobe4), 32'(m_strobe[1]));
    chk({ph, ".ovr4"},    32'(ovr4),    32'(m_ovr[1]));
  endtask

  // Called at a falling edge: drive, let the rising edge sample, check at next fall.
  task automatic cyc(input bit c, input bit r, input bit s, input bit d, input bit sm,
                     input logic [31:0] w);
    cpu_n = c; ras_n = r; cas_n = s; de = d; shift_mode = sm; vram_din = w;
    model_step();
    @(negedge clk);
    compare("cyc");
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    compare("rst");
    reset_n = 1'b1;
  endtask

  logic [7:0] exp4 [5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hDD};

  initial begin
    bit          rc, rr, rs, rd, rsm;
    logic [31:0] rw;
    reset_n = 1'b0; cpu_n = 1'b0; ras_n = 1'b1; cas_n = 1'b1;
    de = 1'b1; shift_mode = 1'b0; vram_din = '0;
    model_reset();
    @(negedge clk);

    // Normal mode, two lanes.
    apply_reset();
    chk("rst.dout2", 32'(dout2), 32'h0);
    chk("rst.lane2", 32'(lane2), 32'h0);
    chk("rst.ovr2",  32'(ovr2),  32'h0);
    cyc(1, 1, 1, 1, 0, 32'hA55A);
    cyc(1, 0, 1, 1, 0, 32'hA55A);
    cyc(1, 0, 0, 1, 0, 32'hA55A);
    chk("n2.byte0", 32'(dout2), 32'h5A);
    chk("n2.strobe0", 32'(strobe2), 32'h1);
    cyc(1, 0, 0, 1, 0, 32'hA55A);
    chk("n2.strobe_hold", 32'(strobe2), 32'h0);
    cyc(1, 0, 1, 1, 0, 32'hA55A);
    chk("n2.lane1", 32'(lane2), 32'h1);
    cyc(1, 0, 0, 1, 0, 32'hA55A);
    chk("n2.byte1", 32'(dout2), 32'hA5);
    chk("n2.strobe1", 32'(strobe2), 32'h1);
    cyc(1, 1, 1, 1, 0, 32'hA55A);
    chk("n2.ovr", 32'(ovr2), 32'h0);
    cyc(0, 1, 1, 1, 0, 32'hA55A);

    // Shift mode with display enable: carry crosses slots.
    apply_reset();
    cyc(1, 1, 1, 1, 1, 32'h1122);
    cyc(1, 0, 0, 1, 1, 32'h1122);
    chk("sh.s1b0", 32'(dout2), 32'h00);
    cyc(1, 0, 1, 1, 1, 32'h1122);
    cyc(1, 0, 0, 1, 1, 32'h1122);
    chk("sh.s1b1", 32'(dout2), 32'h22);
    cyc(1, 1, 1, 1, 1, 32'h1122);
    cyc(0, 1, 1, 1, 1, 32'h3344);
    cyc(1, 1, 1, 1, 1, 32'h3344);
    cyc(1, 0, 0, 1, 1, 32'h3344);
    chk("sh.s2b0", 32'(dout2), 32'h11);
    cyc(1, 0, 1, 1, 1, 32'h3344);
    cyc(1, 0, 0, 1, 1, 32'h3344);
    chk("sh.s2b1", 32'(dout2), 32'h44);
    cyc(1, 1, 1, 1, 1, 32'h3344);
    cyc(0, 1, 1, 1, 1, 32'h3344);

    // Shift mode, display disabled at the last-lane load blanks the carry.
    cyc(1, 1, 1, 1, 1, 32'hBEEF);
    cyc(1, 0, 0, 1, 1, 32'hBEEF);
    chk("blk.s1b0", 32'(dout2), 32'h33);
    cyc(1, 0, 1, 1, 1, 32'hBEEF);
    cyc(1, 0, 0, 0, 1, 32'hBEEF);
    chk("blk.s1b1", 32'(dout2), 32'hEF);
    cyc(1, 1, 1, 0, 1, 32'hBEEF);
    cyc(0, 1, 1, 1, 1, 32'h1234);
    cyc(1, 1, 1, 1, 1, 32'h1234);
    cyc(1, 0, 0, 1, 1, 32'h1234);
    chk("blk.s2b0", 32'(dout2), 32'h00);
    cyc(1, 1, 1, 1, 1, 32'h1234);
    cyc(0, 1, 1, 1, 1, 32'h1234);

    // Four lanes, five CAS pulses: saturation and sticky overrun.
    apply_reset();
    cyc(1, 1, 1, 1, 0, 32'hDDCCBBAA);
    for (int k = 0; k < 5; k++) begin
      cyc(1, 0, 0, 1, 0, 32'hDDCCBBAA);
      chk($sformatf("b4.byte%0d", k), 32'(dout4), 32'(exp4[k]));
      cyc(1, 0, 1, 1, 0, 32'hDDCCBBAA);
    end
    chk("b4.lane_sat", 32'(lane4), 32'h3);
    chk("b4.ovr", 32'(ovr4), 32'h1);
    cyc(0, 1, 1, 1, 0, 32'hDDCCBBAA);
    chk("b4.ovr_sticky", 32'(ovr4), 32'h1);
    chk("b4.lane_clr", 32'(lane4), 32'h0);

    // CPU slot begins on the same clock as a CAS end event.
    cyc(1, 1, 1, 1, 0, 32'h5566);
    cyc(1, 0, 0, 1, 0, 32'h5566);
    cyc(1, 0, 1, 1, 0, 32'h5566);
    cyc(1, 0, 0, 1, 0, 32'h5566);
    chk("cpu.lane_pre", 32'(lane2), 32'h1);
    cyc(0, 0, 1, 1, 0, 32'h5566);
    chk("cpu.lane2", 32'(lane2), 32'h0);
    chk("cpu.lane4", 32'(lane4), 32'h0);
    chk("cpu.dout2", 32'(dout2), 32'h55);

    // Asynchronous reset in the middle of a load window.
    cyc(1, 1, 1, 1, 0, 32'h7788);
    cyc(1, 0, 0, 1, 0, 32'h7788);
    cyc(1, 0, 1, 1, 0, 32'h7788);
    cpu_n = 1'b1; ras_n = 1'b0; cas_n = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst.dout2", 32'(dout2), 32'h0);
    chk("arst.lane2", 32'(lane2), 32'h0);
    chk("arst.ovr2",  32'(ovr2),  32'h0);
    chk("arst.ovr4",  32'(ovr4),  32'h0);
    model_reset();
    @(negedge clk);
    compare("arst");
    reset_n = 1'b1;
    cyc(1, 0, 0, 1, 0, 32'h7788);
    chk("arst.first", 32'(dout2), 32'h88);
    chk("arst.strobe", 32'(strobe2), 32'h1);

    // Randomized traffic.
    rc = 1; rr = 0; rs = 1; rd = 1; rsm = 0; rw = $urandom;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(249) == 0) begin
        #2 reset_n = 1'b0;
        #1 model_reset();
        compare("rarst");
        @(negedge clk);
        reset_n = 1'b1;
      end
      rc = ($urandom_range(15) != 0);
      rr = ($urandom_range(7) == 0);
      if ($urandom_range(1) == 0) rs = ~rs;
      rd = ($urandom_range(3) != 0);
      if ($urandom_range(15) == 0) rsm = ~rsm;
      if ($urandom_range(3) == 0) rw = $urandom;
      cyc(rc, rr, rs, rd, rsm, rw);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
